// File: rtl/vga_sync_decoder_if.sv
// VGA sync wires from the timing source plus the timing recovered from them.
interface vga_sync_decoder_if;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic [9:0]  CounterX;
  logic [9:0]  CounterY;
  logic        inDisplayArea;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_count;
  logic [10:0] line_len;

  modport master (
    output vga_h_sync, vga_v_sync,
    input  CounterX, CounterY, inDisplayArea, locked, sync_err, err_count, line_len
  );
  modport slave (
    input  vga_h_sync, vga_v_sync,
    output CounterX, CounterY, inDisplayArea, locked, sync_err, err_count, line_len
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Rebuilds CounterX/CounterY/inDisplayArea from the VGA sync wires and checks line/frame geometry.
// Optional SYNC_GLITCH_FILTER_EN: 3-sample stability filter on both syncs, output lag 4 instead of 2.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL    = 800,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_SYNC_END = 752,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_SYNC_END = 492
) (
  input logic               clk,
  input logic               reset,
  vga_sync_decoder_if.slave bus
);
  localparam logic [9:0]  X_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  X_LOAD = 10'(H_SYNC_END);
  localparam logic [9:0]  X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  Y_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_LOAD = 10'(V_SYNC_END);
  localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
  localparam logic [10:0] H_LEN  = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN  = 11'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_e;

  logic hs1_q, hs2_q, vs1_q, vs2_q;

`ifdef SYNC_GLITCH_FILTER_EN
  logic hg1_q, hg2_q, vg1_q, vg2_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      {hg1_q, hg2_q, vg1_q, vg2_q} <= 4'hF;
      {hs1_q, hs2_q, vs1_q, vs2_q} <= 4'hF;
    end else begin
      hg1_q <= bus.vga_h_sync;
      hg2_q <= hg1_q;
      vg1_q <= bus.vga_v_sync;
      vg2_q <= vg1_q;
      // Level moves only when the live sample agrees with the two before it.
      if (bus.vga_h_sync == hg1_q && hg1_q == hg2_q) hs1_q <= hg1_q;
      if (bus.vga_v_sync == vg1_q && vg1_q == vg2_q) vs1_q <= vg1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      {hs1_q, hs2_q, vs1_q, vs2_q} <= 4'hF;
    end else begin
      hs1_q <= bus.vga_h_sync;
      hs2_q <= hs1_q;
      vs1_q <= bus.vga_v_sync;
      vs2_q <= vs1_q;
    end
  end
`endif

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d, hcnt_q, hcnt_d;
  logic [10:0] lcnt_q, lcnt_d, line_len_q, line_len_d, frame_lines;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        lines_ok_q, lines_ok_d, first_q, first_d;
  logic        locked_q, locked_d, sync_err_q, sync_err_d, ida_q, ida_d;
  logic        h_edge, v_edge, x_wrap, bad_line, frame_cnt_ok, frame_good;
  logic        restart, enter_track;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= SEARCH;
      x_q        <= '0;
      y_q        <= '0;
      hcnt_q     <= '0;
      lcnt_q     <= '0;
      line_len_q <= '0;
      err_cnt_q  <= '0;
      lines_ok_q <= 1'b1;
      first_q    <= 1'b1;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      ida_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hcnt_q     <= hcnt_d;
      lcnt_q     <= lcnt_d;
      line_len_q <= line_len_d;
      err_cnt_q  <= err_cnt_d;
      lines_ok_q <= lines_ok_d;
      first_q    <= first_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      ida_q      <= ida_d;
    end
  end

  always_comb begin
    h_edge = hs1_q & ~hs2_q;
    v_edge = vs1_q & ~vs2_q;
    x_wrap = (x_q == X_MAX);
    x_d = h_edge ? X_LOAD : (x_wrap ? 10'd0 : x_q + 10'd1);
    y_d = y_q;
    if (x_wrap) y_d = (y_q == Y_MAX) ? 10'd0 : y_q + 10'd1;
    if (v_edge) y_d = Y_LOAD;

    lcnt_d     = h_edge ? 11'd1 : ((lcnt_q == 11'h7FF) ? lcnt_q : lcnt_q + 11'd1);
    line_len_d = h_edge ? lcnt_q : line_len_q;
    // The line right after entering TRACK may be partial, so it is not judged.
    bad_line     = h_edge && !first_q && (lcnt_q != H_LEN);
    frame_lines  = {1'b0, hcnt_q} + {10'd0, h_edge};
    frame_cnt_ok = (frame_lines == V_LEN);
    frame_good   = frame_cnt_ok && lines_ok_q && !bad_line;

    state_d     = state_q;
    sync_err_d  = 1'b0;
    restart     = 1'b0;
    enter_track = 1'b0;
    case (state_q)
      SEARCH: if (v_edge) begin
        state_d     = TRACK;
        restart     = 1'b1;
        enter_track = 1'b1;
      end
      TRACK: if (v_edge) begin
        restart = 1'b1;
        if (frame_good) state_d = LOCKED;
      end
      LOCKED: begin
        if (bad_line || (v_edge && !frame_cnt_ok)) begin
          state_d    = SEARCH;
          sync_err_d = 1'b1;
        end else if (v_edge) begin
          restart = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase

    hcnt_d = hcnt_q;
    if (restart)                     hcnt_d = '0;
    else if (h_edge && hcnt_q != '1) hcnt_d = hcnt_q + 10'd1;
    lines_ok_d = restart ? 1'b1 : (bad_line ? 1'b0 : lines_ok_q);
    first_d    = enter_track ? 1'b1 : (h_edge ? 1'b0 : first_q);
    err_cnt_d  = (sync_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    locked_d   = (state_d == LOCKED);
    ida_d      = locked_d && (x_d < X_ACT) && (y_d < Y_ACT);
  end

  assign bus.CounterX      = x_q;
  assign bus.CounterY      = y_q;
  assign bus.inDisplayArea = ida_q;
  assign bus.locked        = locked_q;
  assign bus.sync_err      = sync_err_q;
  assign bus.err_count     = err_cnt_q;
  assign bus.line_len      = line_len_q;
endmodule
